// File: rtl/data_route_pkg.sv
// Shared data_route constants for the lane packer.
// Beat width, pack ratio, packed word width and lane-count width.
package data_route_pkg;

   localparam int unsigned DR_IN_W   = 256;
   localparam int unsigned DR_RATIO  = 6;
   localparam int unsigned DR_OUT_W  = DR_IN_W * DR_RATIO;
   localparam int unsigned DR_LANE_W = 3;

endpackage

// File: rtl/in256_out1536_pack.sv
// Packs RATIO input beats of IN_W bits into one OUT_W word, beat 0 in the LSBs.
// A word closes early on s_axis_tlast; unfilled lanes are zero and tuser carries the lane count.
module in256_out1536_pack
   import data_route_pkg::*;
#(
   parameter int unsigned IN_W  = DR_IN_W,
   parameter int unsigned RATIO = DR_RATIO
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [IN_W-1:0]           s_axis_tdata,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_tready,
   output logic [IN_W*RATIO-1:0]     m_axis_tdata,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [DR_LANE_W-1:0]      m_axis_tuser,
   output logic [31:0]               word_cnt
);

   localparam int unsigned OUT_W = IN_W * RATIO;

   logic [DR_LANE_W-1:0] idx;
   logic [OUT_W-1:0]     acc;
   logic [OUT_W-1:0]     word_next;
   logic                 accept;
   logic                 last_lane;
   logic                 close;
   logic                 out_hs;

   // Input is throttled only by the output register, never by tvalid/tlast.
   assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign last_lane     = (idx == DR_LANE_W'(RATIO - 1));
   assign close         = accept & (last_lane | s_axis_tlast);
   assign out_hs        = m_axis_tvalid & m_axis_tready;

   always_comb begin
      word_next = acc;
      for (int unsigned k = 0; k < RATIO; k++) begin
         if (accept && (idx == DR_LANE_W'(k))) begin
            word_next[k*IN_W +: IN_W] = s_axis_tdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx           <= '0;
         acc           <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         word_cnt      <= '0;
      end else begin
         if (accept) begin
            // Lanes above idx stay zero because the accumulator is wiped on every close.
            if (close) begin
               idx <= '0;
               acc <= '0;
            end else begin
               idx <= idx + 1'b1;
               acc <= word_next;
            end
         end

         if (close) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= word_next;
            m_axis_tuser  <= idx + 1'b1;
            m_axis_tlast  <= s_axis_tlast;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

         if (out_hs) begin
            word_cnt <= word_cnt + 32'd1;
         end
      end
   end

endmodule

// File: doc/in256_out1536_pack.md
IN256_OUT1536_PACK -- requirements
Module: in256_out1536_pack

Interface
REQ-001 SHALL have parameter IN_W, default 256, input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 6, input beats per output word; OUT_W = IN_W*RATIO (1536).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port s_axis_tdata  input  IN_W  input beat.
REQ-006 SHALL have port s_axis_tvalid  input  1  input beat valid.
REQ-007 SHALL have port s_axis_tlast  input  1  last beat of frame; forces flush.
REQ-008 SHALL have port s_axis_tready  output  1  input beat accept.
REQ-009 SHALL have port m_axis_tdata  output  OUT_W  packed word to inter_switch s_in_*_tdata.
REQ-010 SHALL have port m_axis_tvalid  output  1  packed word valid.
REQ-011 SHALL have port m_axis_tready  input  1  downstream accept.
REQ-012 SHALL have port m_axis_tlast  output  1  word closes a frame.
REQ-013 SHALL have port m_axis_tuser  output  3  count of valid IN_W lanes in word, 1..RATIO.
REQ-014 SHALL have port word_cnt  output  32  packed words emitted since reset, wraps at 2^32.

Function
REQ-015 SHALL accept a beat when s_axis_tvalid & s_axis_tready are high at a rising edge.
REQ-016 SHALL drive s_axis_tready = ~m_axis_tvalid | m_axis_tready; no other dependency (no combinational path from s_axis_tvalid/tlast).
REQ-017 SHALL place accepted beat k of a word (k = 0..RATIO-1) at bits [k*IN_W +: IN_W]; beat 0 in LSBs.
REQ-018 SHALL track lane index idx (0..RATIO-1) in a counter; idx increments per accepted beat, returns to 0 on word close.
REQ-019 SHALL close a word when an accepted beat has idx = RATIO-1 or s_axis_tlast = 1.
REQ-020 SHALL, on close, load output register in the same edge: tdata = accumulated lanes plus current beat, unfilled lanes zero, tuser = idx+1, tlast = s_axis_tlast; m_axis_tvalid = 1 next cycle (1-cycle latency from closing beat).
REQ-021 SHALL clear accumulator lanes to zero on every close so partial words never carry stale data.
REQ-022 SHALL hold m_axis_tdata/tuser/tlast stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-023 SHALL clear m_axis_tvalid after handshake unless a new word closes on the same edge, in which case tvalid stays 1 with new contents (full throughput, one word per RATIO beats).
REQ-024 SHALL, for a non-closing beat while output is stalled, stall input (tready = 0) rather than accumulate further; accumulator never overruns.
REQ-025 SHALL increment word_cnt by 1 on each m_axis handshake; 0xFFFFFFFF wraps to 0.
REQ-026 SHALL treat tlast on beat idx = RATIO-1 as one close (tuser = RATIO, tlast = 1), not two.

Reset
REQ-027 SHALL on rst_n = 0, asynchronously: idx = 0, accumulator = 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0, word_cnt = 0; s_axis_tready = 1 follows from REQ-016.
REQ-028 SHALL discard any partial word and any pending output on reset mid-operation; no output until RATIO new beats or tlast.

Structure
REQ-029 SHALL take IN_W, RATIO, OUT_W and the lane-count width from the shared data_route package constants.
REQ-030 SHALL be a single module; lane write-enable decode may use the existing decoder_3_8 as its only sub-module.

Verification
REQ-031 SHALL cover: 6 beats 0x01..0x06 (lane-replicated bytes), tready=1 -> one word, lane k = beat k+1, tuser=6, tlast=0, tvalid 1 cycle after beat 6.
REQ-032 SHALL cover: 2 beats, second with tlast -> word lanes 0-1 data, lanes 2-5 zero, tuser=2, tlast=1.
REQ-033 SHALL cover: 12 continuous beats, m_axis_tready held 0 for 10 cycles after first word -> tready drops, first word held stable, second word intact, word_cnt=2.
REQ-034 SHALL cover: tlast on 6th beat -> single word, tuser=6, tlast=1, word_cnt += 1.
REQ-035 SHALL cover: rst_n pulsed low after 3 beats -> no output; next 6 beats form clean word, no stale lanes.
REQ-036 SHALL cover: word_cnt preloaded via force to 0xFFFFFFFF, one handshake -> word_cnt=0.
